// File: rtl/rf_pkg.sv
// Shared constants and the write-port priority resolver for reg_file_mp.
// The resolver is used by both the register write path and the read bypass.
package rf_pkg;

    localparam int ZERO_REG      = 0;
    localparam int DEFAULT_DW    = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int MAX_WR        = 4;
    localparam int WSEL_W        = $clog2(MAX_WR);

    typedef struct packed {
        logic              hit;
        logic [WSEL_W-1:0] port;
    } wsel_t;

    // The highest-index matching port wins when several hit the same register.
    function automatic wsel_t wr_select(input logic [MAX_WR-1:0] match);
        wsel_t s;
        s.hit  = 1'b0;
        s.port = '0;
        for (int p = 0; p < MAX_WR; p++) begin
            if (match[p]) begin
                s.hit  = 1'b1;
                s.port = WSEL_W'(p);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared by a committing write,
// with issue taking precedence when both target the same register.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [DEPTH-1:0]  busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
            if (iss_en && (iss_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with busy scoreboard and a non-bypassed debug port.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [AW-1:0]     debug_ra,
    output logic [DW-1:0]     debug_rd
);

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] busy;

    always_comb begin
        logic [MAX_WR-1:0] match;
        wsel_t             sel;
        match = '0;
        sel   = '0;
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = regs_q[r];
            if (r != ZERO_REG) begin
                match = '0;
                for (int p = 0; p < NWR; p++) begin
                    match[p] = wr_en[p] && (wr_addr[p*AW +: AW] == AW'(r));
                end
                sel = wr_select(match);
                if (sel.hit) begin
                    regs_d[r] = wr_data[int'(sel.port)*DW +: DW];
                end
            end
        end
    end

    // Register 0 never takes a write, so it holds its reset value of zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                regs_q[gi] <= '0;
            end else begin
                regs_q[gi] <= regs_d[gi];
            end
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy)
    );

    always_comb begin
        logic [AW-1:0] ra;
`ifdef REG_FILE_MP_BYPASS_EN
        logic [MAX_WR-1:0] fwd_match;
        wsel_t             fwd_sel;
        fwd_match = '0;
        fwd_sel   = '0;
`endif
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra                 = rd_addr[k*AW +: AW];
            rd_data[k*DW +: DW] = regs_q[ra];
            rd_busy[k]         = busy[ra];
`ifdef REG_FILE_MP_BYPASS_EN
            fwd_match = '0;
            for (int p = 0; p < NWR; p++) begin
                fwd_match[p] = wr_en[p] && (wr_addr[p*AW +: AW] == ra) &&
                               (ra != AW'(ZERO_REG));
            end
            fwd_sel = wr_select(fwd_match);
            if (fwd_sel.hit) begin
                rd_data[k*DW +: DW] = wr_data[int'(fwd_sel.port)*DW +: DW];
                rd_busy[k]          = 1'b0;
            end
`endif
        end
    end

    assign debug_rd = regs_q[debug_ra];

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default 32x32, 2 read / 2 write ports).
module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic              clk;
    logic              rstn;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic [AW-1:0]     debug_ra;
    logic [DW-1:0]     debug_rd;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_data_q[$];
    logic          exp_busy_q[$];

    reg_file_mp #(.DW(DW), .DEPTH(32), .NRD(NRD), .NWR(NWR)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .debug_ra (debug_ra),
        .debug_rd (debug_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic drv_idle();
        wr_en  = '0;
        iss_en = 1'b0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic test_reset();
        logic [DW-1:0] e;
        logic          b;
        set_rd(0, 5);
        debug_ra = 5;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL reset_init_data got %h exp %h", rd_data[31:0], 32'h0);
        end
        drv_wr(0, 5, 32'hDEADBEEF);
        exp_data_q.push_back(32'hDEADBEEF);
        tick();
        drv_idle();
        iss_en = 1'b1; iss_addr = 5;
        tick();
        drv_idle();
        exp_busy_q.push_back(1'b1);
        #1;
        e = exp_data_q.pop_front();
        b = exp_busy_q.pop_front();
        checks++;
        if (rd_data[31:0] !== e || rd_busy[0] !== b) begin
            errors++; $display("FAIL pre_reset_x5 got %h/%b exp %h/%b", rd_data[31:0], rd_busy[0], e, b);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0 || debug_rd !== 32'h0) begin
            errors++; $display("FAIL async_reset got %h/%b dbg %h exp 0/0/0", rd_data[31:0], rd_busy[0], debug_rd);
        end
        rstn = 1'b1;
        tick();
        drv_wr(0, 5, 32'h1);
        exp_data_q.push_back(32'h1);
        tick();
        drv_idle();
        #1;
        e = exp_data_q.pop_front();
        checks++;
        if (rd_data[31:0] !== e || rd_busy[0] !== 1'b0) begin
            errors++; $display("FAIL post_reset_write got %h/%b exp %h/0", rd_data[31:0], rd_busy[0], e);
        end
    endtask

    task automatic test_zero_reg();
        drv_wr(0, 0, 32'hFFFFFFFF);
        drv_wr(1, 0, 32'hFFFFFFFF);
        iss_en = 1'b1; iss_addr = 0;
        exp_data_q.push_back(32'h0);
        tick();
        drv_idle();
        set_rd(0, 0);
        debug_ra = 0;
        #1;
        checks++;
        if (rd_data[31:0] !== exp_data_q[0] || rd_busy[0] !== 1'b0 || debug_rd !== exp_data_q[0]) begin
            errors++; $display("FAIL x0_immune got %h/%b dbg %h exp %h/0", rd_data[31:0], rd_busy[0], debug_rd, exp_data_q[0]);
        end
        void'(exp_data_q.pop_front());
    endtask

    task automatic test_dual_write();
        logic [DW-1:0] e0, e1;
        drv_wr(0, 7, 32'h11);
        drv_wr(1, 7, 32'h22);
        exp_data_q.push_back(32'h22);
        tick();
        drv_idle();
        set_rd(1, 7);
        #1;
        e1 = exp_data_q.pop_front();
        checks++;
        if (rd_data[63:32] !== e1) begin
            errors++; $display("FAIL same_addr_priority got %h exp %h", rd_data[63:32], e1);
        end
        drv_wr(0, 8, 32'h33);
        drv_wr(1, 9, 32'h44);
        exp_data_q.push_back(32'h33);
        exp_data_q.push_back(32'h44);
        tick();
        drv_idle();
        set_rd(0, 8);
        set_rd(1, 9);
        #1;
        e0 = exp_data_q.pop_front();
        e1 = exp_data_q.pop_front();
        checks++;
        if (rd_data[31:0] !== e0 || rd_data[63:32] !== e1) begin
            errors++; $display("FAIL dual_commit got %h,%h exp %h,%h", rd_data[31:0], rd_data[63:32], e0, e1);
        end
    endtask

    task automatic test_scoreboard();
        logic b;
        logic [DW-1:0] e;
        iss_en = 1'b1; iss_addr = 3;
        exp_busy_q.push_back(1'b1);
        tick();
        drv_idle();
        set_rd(0, 3);
        #1;
        b = exp_busy_q.pop_front();
        checks++;
        if (rd_busy[0] !== b) begin
            errors++; $display("FAIL issue_sets_busy got %b exp %b", rd_busy[0], b);
        end
        drv_wr(1, 3, 32'h55);
        exp_busy_q.push_back(1'b0);
        exp_data_q.push_back(32'h55);
        tick();
        drv_idle();
        #1;
        b = exp_busy_q.pop_front();
        e = exp_data_q.pop_front();
        checks++;
        if (rd_busy[0] !== b || rd_data[31:0] !== e) begin
            errors++; $display("FAIL write_clears_busy got %b/%h exp %b/%h", rd_busy[0], rd_data[31:0], b, e);
        end
        iss_en = 1'b1; iss_addr = 4;
        drv_wr(0, 4, 32'h66);
        exp_busy_q.push_back(1'b1);
        exp_data_q.push_back(32'h66);
        tick();
        drv_idle();
        set_rd(1, 4);
        #1;
        b = exp_busy_q.pop_front();
        e = exp_data_q.pop_front();
        checks++;
        if (rd_busy[1] !== b || rd_data[63:32] !== e) begin
            errors++; $display("FAIL issue_beats_write got %b/%h exp %b/%h", rd_busy[1], rd_data[63:32], b, e);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] e;
        logic          b;
        drv_wr(0, 6, 32'h1111);
        tick();
        drv_idle();
        iss_en = 1'b1; iss_addr = 6;
        tick();
        drv_idle();
        drv_wr(1, 6, 32'hABCD);
        set_rd(0, 6);
        debug_ra = 6;
`ifdef REG_FILE_MP_BYPASS_EN
        exp_data_q.push_back(32'hABCD);
        exp_busy_q.push_back(1'b0);
`else
        exp_data_q.push_back(32'h1111);
        exp_busy_q.push_back(1'b1);
`endif
        #1;
        e = exp_data_q.pop_front();
        b = exp_busy_q.pop_front();
        checks++;
        if (rd_data[31:0] !== e || rd_busy[0] !== b) begin
            errors++; $display("FAIL bypass_same_cycle got %h/%b exp %h/%b", rd_data[31:0], rd_busy[0], e, b);
        end
        checks++;
        if (debug_rd !== 32'h1111) begin
            errors++; $display("FAIL debug_not_bypassed got %h exp %h", debug_rd, 32'h1111);
        end
        tick();
        drv_idle();
        #1;
        checks++;
        if (rd_data[31:0] !== 32'hABCD || rd_busy[0] !== 1'b0) begin
            errors++; $display("FAIL bypass_next_cycle got %h/%b exp %h/0", rd_data[31:0], rd_busy[0], 32'hABCD);
        end
    endtask

    task automatic test_debug();
        debug_ra = 10;
        drv_wr(1, 10, 32'h1234);
        exp_data_q.push_back(32'h1234);
        #1;
        checks++;
        if (debug_rd !== 32'h0) begin
            errors++; $display("FAIL debug_before_edge got %h exp %h", debug_rd, 32'h0);
        end
        tick();
        drv_idle();
        #1;
        checks++;
        if (debug_rd !== exp_data_q[0]) begin
            errors++; $display("FAIL debug_after_edge got %h exp %h", debug_rd, exp_data_q[0]);
        end
        void'(exp_data_q.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] model [32];
        logic [DW-1:0] e;
        for (int r = 11; r < 27; r++) model[r] = $urandom;
        for (int r = 11; r < 27; r += 2) begin
            drv_wr(0, AW'(r), model[r]);
            drv_wr(1, AW'(r + 1), model[r + 1]);
            tick();
            drv_idle();
        end
        for (int r = 11; r < 27; r++) exp_data_q.push_back(model[r]);
        for (int r = 11; r < 27; r += 2) begin
            set_rd(0, AW'(r));
            set_rd(1, AW'(r + 1));
            #1;
            e = exp_data_q.pop_front();
            checks++;
            if (rd_data[31:0] !== e) begin
                errors++; $display("FAIL b2b_x%0d got %h exp %h", r, rd_data[31:0], e);
            end
            e = exp_data_q.pop_front();
            checks++;
            if (rd_data[63:32] !== e) begin
                errors++; $display("FAIL b2b_x%0d got %h exp %h", r + 1, rd_data[63:32], e);
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        debug_ra = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        tick();
        test_reset();
        test_zero_reg();
        test_dual_write();
        test_scoreboard();
        test_bypass();
        test_debug();
        test_back_to_back();
        checks++;
        if (exp_data_q.size() != 0 || exp_busy_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d/%0d exp 0/0", exp_data_q.size(), exp_busy_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU datapath. Successor to the single-write, two-read register file.
- Configurable data width, depth, read-port count and write-port count.
- Adds asynchronous clearing of all registers and an integrated per-register busy scoreboard that the hazard unit consumes.
- Keeps the debug read port used by the PDU/debug console.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, ≥ 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NRD, 2, number of read ports (1..4).
- NWR, 2, number of write ports (1..2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*DW  packed read data, combinational.
- rd_busy  out  NRD  1 = register addressed by read port k has a pending write.
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses.
- wr_data  in  NWR*DW  packed write data.
- iss_en  in  1  issue strobe: marks iss_addr busy.
- iss_addr  in  AW  destination register of the issuing instruction.
- debug_ra  in  AW  debug read address.
- debug_rd  out  DW  debug read data, combinational; never bypassed.

Behaviour:
- Reset: rstn low asynchronously clears every register to 0 and every busy bit to 0. rd_data, debug_rd and rd_busy then read 0. Normal operation resumes on the first rising edge after rstn deasserts. A reset that asserts mid-write discards that write.
- Register 0 always reads 0 and is never busy. Writes and issues to address 0 are ignored.
- Writes take effect at the rising edge when wr_en[p]=1 and wr_addr[p]≠0.
  - Two ports writing the same address in one cycle: the higher port index wins.
  - Different addresses: both writes commit.
- Reads are combinational from stored state; zero read latency. Out-of-range addresses cannot occur because DEPTH = 2^AW.
- Scoreboard state: one busy bit per register.
  - Set at the edge when iss_en=1 and iss_addr≠0.
  - Cleared at the edge by any committing write to that address.
  - Issue and write to the same address in the same cycle: busy ends set, because the new producer takes precedence.
  - Issue to an address that is already busy: stays busy. Busy is a single bit with no counter; the hazard unit guarantees only one outstanding producer per register.
- rd_busy[k] = busy[rd_addr[k]], subject to the bypass rule under Optional Feature.
- debug_rd: stored value, same read rules as the read ports, no bypass.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If any wr_en[p]=1 with wr_addr[p]=rd_addr[k]≠0 in the current cycle, rd_data[k] = wr_data of the highest matching port index.
  - rd_busy[k] = 0 for that read, even though the busy bit itself clears only at the edge.
- Undefined:
  - rd_data returns the stored value only; new data is visible the cycle after the write.
  - rd_busy[k] reflects the stored busy bit.

Decomposition:
- Package rf_pkg:
  - ZERO_REG constant (0).
  - Default DW/DEPTH constants.
  - Function for priority-resolved write selection, shared by the write path and the bypass.
- One natural sub-module, rf_scoreboard. It holds the busy vector with its set/clear/precedence rules and the asynchronous clear, and takes the wr_en/wr_addr vectors plus iss_en/iss_addr as inputs.

Test Plan:
1. Reset clears state: write 0xDEADBEEF to x5, then pulse rstn low between edges → rd_data for x5 = 0 immediately and rd_busy = 0; after release, a write of 0x1 to x5 commits normally.
2. Register 0 is immune: wr_en[0]=1, addr 0, data 0xFFFFFFFF, plus iss_en with iss_addr=0 → x0 reads 0 and is not busy.
3. Dual-write conflict: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle → x7 reads 0x22 next cycle. Then port0 x8=0x33 and port1 x9=0x44 in the same cycle → both commit.
4. Scoreboard:
   - Issue x3 → rd_busy=1 next cycle.
   - Write x3=0x55 → busy=0 next cycle, x3 reads 0x55.
   - Same-cycle issue x4 and write x4 → x4 stays busy.
5. Bypass:
   - Macro defined: read x6 while writing x6=0xABCD in the same cycle → rd_data=0xABCD and rd_busy=0 in that cycle.
   - Macro undefined: old value that cycle, 0xABCD the next cycle.
6. Debug port: write x10=0x1234 → debug_rd shows 0x1234 only after the edge, in both macro builds.
